// File: rtl/pong_pkg.sv
// Shared definitions for the pong end-of-round banner: event codes, message
// indices, banner sequencer states and glyph geometry.
package pong_pkg;

  localparam int CHAR_PITCH = 31;

  localparam logic [1:0] EV_DRAW   = 2'd0;
  localparam logic [1:0] EV_P1_WIN = 2'd1;
  localparam logic [1:0] EV_P2_WIN = 2'd2;
  localparam logic [1:0] EV_RSVD   = 2'd3;

  localparam logic [1:0] MSG_DRAW   = 2'd0;
  localparam logic [1:0] MSG_P1_WIN = 2'd1;
  localparam logic [1:0] MSG_P2_WIN = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SLIDE = 3'd1,
    HOLD  = 3'd2,
    BLINK = 3'd3,
    SHOW  = 3'd4
  } banner_state_t;

  // Map a game-result event onto the renderer's message index.
  function automatic logic [1:0] ev_to_msg(input logic [1:0] code);
    logic [1:0] msg;
    msg = MSG_DRAW;
    case (code)
      EV_DRAW:   msg = MSG_DRAW;
      EV_P1_WIN: msg = MSG_P1_WIN;
      EV_P2_WIN: msg = MSG_P2_WIN;
      default:   msg = MSG_DRAW;
    endcase
    return msg;
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// Frame-tick qualified loadable down-counter with a zero flag.
// Priority: clr > load > tick; the count saturates at zero.
module frame_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (tick && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/banner_ctrl.sv
// End-of-round banner sequencer: slide-in, hold, blink, steady show.
// Build option BANNER_SLIDE_EN enables the slide-in animation; without it the
// banner appears directly at its centred position.
module banner_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W      = 640,
  parameter int MSG_W         = 4 * CHAR_PITCH,
  parameter int TARGET_Y      = 200,
  parameter int SLIDE_STEP    = 8,
  parameter int HOLD_FRAMES   = 120,
  parameter int BLINK_PERIOD  = 16,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        event_valid,
  input  logic [1:0]  event_code,
  output logic        event_ready,
  input  logic        clear,
  output logic [1:0]  msg_sel,
  output logic [31:0] start_x,
  output logic [31:0] start_y,
  output logic        banner_en,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] TX    = 32'((SCREEN_W - MSG_W) / 2);
  localparam logic [31:0] X_OFF = 32'(SCREEN_W);
  localparam logic [31:0] Y_TGT = 32'(TARGET_Y);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam int BW = $clog2(BLINK_PERIOD + 1);
  localparam int TW = $clog2(BLINK_TOGGLES + 1);

  banner_state_t state_reg;
  logic [1:0]    msg_sel_reg;
  logic [31:0]   start_x_reg;
  logic [31:0]   start_y_reg;
  logic          banner_en_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [TW-1:0] toggle_cnt_reg;

  logic accept;
  logic ev_start;
  logic hold_tick;
  logic hold_zero;
  logic hold_expire;
  logic hold_load;
  logic blink_tick;
  logic blink_zero;
  logic period_expire;
  logic last_toggle;
  logic blink_load;

  assign event_ready = (state_reg == IDLE) || (state_reg == SHOW);

  // clear outranks any event offered in the same cycle.
  assign accept   = event_valid && event_ready && !clear;
  assign ev_start = accept && (event_code != EV_RSVD);

  assign hold_tick   = frame_tick && (state_reg == HOLD);
  assign hold_expire = hold_tick && hold_zero;

  assign blink_tick    = frame_tick && (state_reg == BLINK);
  assign period_expire = blink_tick && blink_zero;
  assign last_toggle   = period_expire && (toggle_cnt_reg == TW'(BLINK_TOGGLES - 1));

`ifdef BANNER_SLIDE_EN
  logic slide_arrive;

  // Compare against TX + step so the subtract can never wrap.
  assign slide_arrive = (state_reg == SLIDE) && frame_tick &&
                        (start_x_reg <= TX + 32'(SLIDE_STEP));
  assign hold_load    = !clear && slide_arrive;
`else
  assign hold_load    = !clear && ev_start;
`endif

  assign blink_load = !clear && (hold_expire || (period_expire && !last_toggle));

  // Timers are loaded with N-1 so expiry lines up with the N-th tick.
  frame_down_counter #(.W(HW)) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (clear),
    .load     (hold_load),
    .load_val (HW'(HOLD_FRAMES - 1)),
    .tick     (hold_tick),
    .zero     (hold_zero)
  );

  frame_down_counter #(.W(BW)) u_blink_timer (
    .clk      (clk),
    .reset    (reset),
    .clr      (clear),
    .load     (blink_load),
    .load_val (BW'(BLINK_PERIOD - 1)),
    .tick     (blink_tick),
    .zero     (blink_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      msg_sel_reg    <= MSG_DRAW;
      start_x_reg    <= X_OFF;
      start_y_reg    <= Y_TGT;
      banner_en_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      toggle_cnt_reg <= '0;
    end else begin
      done_reg    <= 1'b0;
      start_y_reg <= Y_TGT;
      if (clear) begin
        state_reg      <= IDLE;
        start_x_reg    <= X_OFF;
        banner_en_reg  <= 1'b0;
        busy_reg       <= 1'b0;
        toggle_cnt_reg <= '0;
      end else begin
        case (state_reg)
          IDLE, SHOW: begin
            if (ev_start) begin
              msg_sel_reg    <= ev_to_msg(event_code);
              banner_en_reg  <= 1'b1;
              busy_reg       <= 1'b1;
              toggle_cnt_reg <= '0;
`ifdef BANNER_SLIDE_EN
              start_x_reg    <= X_OFF;
              state_reg      <= SLIDE;
`else
              start_x_reg    <= TX;
              state_reg      <= HOLD;
`endif
            end
          end
`ifdef BANNER_SLIDE_EN
          SLIDE: begin
            if (slide_arrive) begin
              start_x_reg <= TX;
              state_reg   <= HOLD;
            end else if (frame_tick) begin
              start_x_reg <= start_x_reg - 32'(SLIDE_STEP);
            end
          end
`endif
          HOLD: begin
            if (hold_expire) begin
              toggle_cnt_reg <= '0;
              state_reg      <= BLINK;
            end
          end
          BLINK: begin
            if (period_expire) begin
              toggle_cnt_reg <= toggle_cnt_reg + 1'b1;
              if (last_toggle) begin
                state_reg     <= SHOW;
                banner_en_reg <= 1'b1;
                busy_reg      <= 1'b0;
                done_reg      <= 1'b1;
              end else begin
                banner_en_reg <= !banner_en_reg;
              end
            end
          end
          default: begin
            state_reg     <= IDLE;
            banner_en_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign msg_sel   = msg_sel_reg;
  assign start_x   = start_x_reg;
  assign start_y   = start_y_reg;
  assign banner_en = banner_en_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_banner_ctrl.sv
// Directed self-checking bench for banner_ctrl; follows BANNER_SLIDE_EN so the
// same bench covers both builds.
module tb_banner_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        event_valid;
  logic [1:0]  event_code;
  logic        event_ready;
  logic        clear;
  logic [1:0]  msg_sel;
  logic [31:0] start_x;
  logic [31:0] start_y;
  logic        banner_en;
  logic        busy;
  logic        done;

  int pass_cnt  = 0;
  int total_cnt = 0;

`ifdef BANNER_SLIDE_EN
  localparam logic [31:0] X_ACCEPT = 32'd640;
`else
  localparam logic [31:0] X_ACCEPT = 32'd258;
`endif

  banner_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .event_valid (event_valid),
    .event_code  (event_code),
    .event_ready (event_ready),
    .clear       (clear),
    .msg_sel     (msg_sel),
    .start_x     (start_x),
    .start_y     (start_y),
    .banner_en   (banner_en),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic send(input logic [1:0] code, input logic with_tick);
    event_valid = 1'b1;
    event_code  = code;
    frame_tick  = with_tick;
    step();
    event_valid = 1'b0;
    frame_tick  = 1'b0;
    $display("event code=%0d tick=%0d -> msg_sel=%0d busy=%0d start_x=%0d",
             code, with_tick, msg_sel, busy, start_x);
  endtask

  initial begin
    logic exp_en;
    reset       = 1'b1;
    frame_tick  = 1'b0;
    event_valid = 1'b0;
    event_code  = 2'd0;
    clear       = 1'b0;
    step();
    step();
    check("rst_start_x", start_x, 640);
    check("rst_start_y", start_y, 200);
    check("rst_msg_sel", msg_sel, 0);
    check("rst_banner_en", banner_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_event_ready", event_ready, 1);

    reset = 1'b0;
    step();
    frame();
    check("idle_tick_x", start_x, 640);

    send(2'd3, 1'b0);
    check("rsvd_busy", busy, 0);
    check("rsvd_en", banner_en, 0);
    check("rsvd_ready", event_ready, 1);

    send(2'd0, 1'b0);
    check("draw_msg", msg_sel, 0);
    check("draw_busy", busy, 1);
    check("draw_en", banner_en, 1);
    check("draw_ready", event_ready, 0);
    check("draw_x", start_x, X_ACCEPT);

`ifdef BANNER_SLIDE_EN
    for (int k = 1; k <= 47; k++) begin
      frame();
      check("slide_x", start_x, 32'(640 - 8 * k));
    end
    frame();
    check("slide_final_x", start_x, 258);
`endif

    send(2'd2, 1'b0);
    check("hold_ev_msg", msg_sel, 0);
    check("hold_ev_ready", event_ready, 0);
    check("hold_busy", busy, 1);

    repeat (119) frame();
    check("hold119_en", banner_en, 1);
    check("hold119_busy", busy, 1);
    frame();
    check("blink_entry_en", banner_en, 1);

    for (int t = 1; t <= 96; t++) begin
      frame();
      exp_en = ((t / 16) % 2 == 1) ? 1'b0 : 1'b1;
      check("blink_en", banner_en, exp_en);
      check("blink_done", done, (t == 96) ? 1 : 0);
    end
    check("show_busy", busy, 0);
    check("show_ready", event_ready, 1);
    step();
    check("done_one_cycle", done, 0);
    frame();
    check("show_tick_en", banner_en, 1);
    check("show_tick_busy", busy, 0);

    send(2'd2, 1'b0);
    check("show_ev_msg", msg_sel, 2);
    check("show_ev_busy", busy, 1);
    check("show_ev_x", start_x, X_ACCEPT);

`ifdef BANNER_SLIDE_EN
    repeat (48) frame();
`endif
    repeat (120) frame();
    repeat (5) frame();
    check("blink5_en", banner_en, 1);

    clear       = 1'b1;
    event_valid = 1'b1;
    event_code  = 2'd1;
    frame_tick  = 1'b1;
    step();
    clear       = 1'b0;
    event_valid = 1'b0;
    frame_tick  = 1'b0;
    $display("clear with event code=1 and tick -> busy=%0d banner_en=%0d", busy, banner_en);
    check("clr_en", banner_en, 0);
    check("clr_x", start_x, 640);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_msg_hold", msg_sel, 2);
    check("clr_ready", event_ready, 1);

    send(2'd1, 1'b1);
    check("acc_tick_msg", msg_sel, 1);
    check("acc_tick_busy", busy, 1);
    check("acc_tick_x", start_x, X_ACCEPT);

`ifdef BANNER_SLIDE_EN
    repeat (30) frame();
    check("mid_slide_x", start_x, 400);
`else
    repeat (10) frame();
    check("mid_hold_x", start_x, 258);
`endif
    #2 reset = 1'b1;
    #1;
    check("async_rst_x", start_x, 640);
    check("async_rst_en", banner_en, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", event_ready, 1);
    check("async_rst_msg", msg_sel, 0);
    step();
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
